bomb_defuse_input: RTL and testbench
====================================

# bomb_defuse_input

Input-side companion to the bomb countdown controller. Conditions raw push-buttons and digit switches from the board (2-flop synchronisation, debounce, press-edge detection), issues the one-cycle `start_countdown` request the controller consumes, then collects a decimal defuse code digit by digit and compares it against a fixed secret. Reports success (`defused`) or exhaustion of attempts (`locked_out`). Sits between the board I/O pins and the countdown controller's `start_countdown` input.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised cycles required before a debounced level changes (10 ms at 50 MHz). Must be ≥ 2.
- `CODE_DIGITS`, default 4: number of BCD digits in the code (1..8).
- `SECRET_CODE`, default 32'h0000_1234: secret code, BCD, right-aligned; only the low 4*CODE_DIGITS bits are used.
- `MAX_ATTEMPTS`, default 3: wrong codes allowed before lockout (1..15).

Ports:
- `clk`  in  1  system clock. All state is on the rising edge; one clock, no other clock domains.
- `async_nreset`  in  1  asynchronous, active-low reset.
- `btn_arm`  in  1  raw arm button, active high, asynchronous to `clk`.
- `btn_enter`  in  1  raw digit-enter button, active high, asynchronous.
- `digit_in`  in  4  raw digit switches, asynchronous.
- `start_countdown`  out  1  one-cycle pulse that arms the countdown.
- `defused`  out  1  level; the correct code has been entered.
- `locked_out`  out  1  level; MAX_ATTEMPTS wrong codes have been entered.
- `digits_entered`  out  4  number of digits accepted in the current attempt.
- `attempts_used`  out  4  wrong attempts so far.

## Operation
- Every raw input passes through its own 2-flop synchroniser.
- Each button also has a debounce counter:
  - The counter runs while the synchronised value differs from the debounced level.
  - It clears whenever they are equal.
  - When it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
- A press event is a 1-cycle pulse generated on a rising edge of the debounced level. Releases generate nothing.
- The FSM has five states: IDLE, ENTRY, CHECK, DEFUSED, LOCKED.
  - IDLE:
    - An arm press pulses `start_countdown`, clears the entry register and `digits_entered`, and moves to ENTRY.
    - Enter presses are ignored.
  - ENTRY:
    - An enter press samples synchronised `digit_in`.
    - A value > 9 is discarded; state and counters are unchanged.
    - A valid value is shifted into the entry register from the low end, so the first digit ends up as the most significant nibble. `digits_entered` increments.
    - When `digits_entered` reaches CODE_DIGITS, the FSM moves to CHECK.
    - Arm presses are ignored.
  - CHECK lasts exactly one cycle and compares the entry register with SECRET_CODE[4*CODE_DIGITS-1:0].
    - Match: go to DEFUSED.
    - Mismatch: increment `attempts_used`. If the new value equals MAX_ATTEMPTS, go to LOCKED. Otherwise clear the entry register and `digits_entered` and return to ENTRY.
  - DEFUSED and LOCKED are terminal. All presses are ignored and only reset leaves them.
- `defused` is high exactly when the FSM is in DEFUSED, and `locked_out` exactly when it is in LOCKED. Both are registered.
- Reset values:
  - FSM in IDLE.
  - All outputs 0.
  - Synchronisers, debounced levels and debounce counters 0.
- Reset is honoured mid-debounce or mid-entry, and all progress is lost.
- A button already held during reset release produces a press once its debounce completes, because the debounced level resets to 0.

## Timing
- Raw rising edge on a clean, held button at clock edge t:
  - The synchronised value changes at t+2.
  - The debounced level rises at t+2+DEBOUNCE_CYCLES.
  - The press pulse is high during the following cycle.
  - `start_countdown` (registered) is high for the single cycle starting at t+4+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no press.
- Digit accept: `digits_entered` updates one cycle after the enter press pulse.
  - `digit_in` is sampled from its synchroniser output in the press cycle.
  - `digit_in` must be stable for ≥ 3 cycles before the press pulse.
- After the last digit, CHECK follows on the next edge. `defused`, `locked_out` or the cleared entry become visible one cycle after CHECK.
- Arm and enter presses in the same cycle: only the press relevant to the current state is acted on; the other is dropped.
- `attempts_used` saturates at MAX_ATTEMPTS and never wraps.

## Test plan
Benches use DEBOUNCE_CYCLES=4, CODE_DIGITS=4, SECRET_CODE=16'h1234, MAX_ATTEMPTS=3.
- Reset/arm:
  - After reset, all outputs are 0.
  - Holding `btn_arm` from edge t gives `start_countdown`=1 only in the cycle starting at t+8, and no second pulse while held.
- Glitch rejection: 3-cycle `btn_arm` and `btn_enter` pulses in IDLE give no `start_countdown` and no state change.
- Correct code: arm, then enter 1,2,3,4.
  - `digits_entered` steps 1..4.
  - `defused`=1 two cycles after the 4th accept.
  - Further presses change nothing.
- Invalid digit: in ENTRY, enter with `digit_in`=4'hA leaves `digits_entered` unchanged; entry continues normally afterwards.
- Lockout:
  - Three wrong codes (1,2,3,5) give `attempts_used` 1,2,3 and `digits_entered` back to 0 after the first two.
  - `locked_out`=1 after the third.
  - A subsequent correct code is ignored.
- Reset mid-entry: after 2 digits, assert `async_nreset` asynchronously.
  - All outputs are 0 immediately.
  - After release, the FSM requires a new arm press.

Source files
------------

// File: rtl/bomb_defuse_input_if.sv
// Board-side signal bundle for bomb_defuse_input: raw buttons and digit
// switches in, countdown request and code-entry status out.
interface bomb_defuse_input_if;
  logic       btn_arm;
  logic       btn_enter;
  logic [3:0] digit_in;
  logic       start_countdown;
  logic       defused;
  logic       locked_out;
  logic [3:0] digits_entered;
  logic [3:0] attempts_used;

  // Board / stimulus side: drives the raw inputs, observes status.
  modport master (
    output btn_arm,
    output btn_enter,
    output digit_in,
    input  start_countdown,
    input  defused,
    input  locked_out,
    input  digits_entered,
    input  attempts_used
  );

  // Design side: consumes raw inputs, produces status.
  modport slave (
    input  btn_arm,
    input  btn_enter,
    input  digit_in,
    output start_countdown,
    output defused,
    output locked_out,
    output digits_entered,
    output attempts_used
  );
endinterface

// File: rtl/bomb_defuse_input.sv
// Input conditioning and defuse-code entry for the bomb countdown.
// Raw buttons are synchronised, debounced and edge-detected; the arm press
// issues a one-cycle start_countdown, then BCD digits are collected and
// compared against SECRET_CODE, ending in DEFUSED or LOCKED.
module bomb_defuse_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CODE_DIGITS     = 4,
  parameter logic [31:0] SECRET_CODE     = 32'h0000_1234,
  parameter int unsigned MAX_ATTEMPTS    = 3
) (
  input  logic               clk,
  input  logic               async_nreset,
  bomb_defuse_input_if.slave io
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int unsigned    CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [63:0]    CODE_MASK64  = (64'd1 << (4 * CODE_DIGITS)) - 64'd1;
  localparam logic [31:0]    CODE_MASK    = CODE_MASK64[31:0];
  localparam logic [31:0]    SECRET_MASKED = SECRET_CODE & CODE_MASK;
  localparam logic [3:0]     DIGITS_FULL  = 4'(CODE_DIGITS);
  localparam logic [3:0]     ATTEMPTS_MAX = 4'(MAX_ATTEMPTS);

  // Button index 0 = arm, 1 = enter.
  localparam int unsigned    BTN_ARM   = 0;
  localparam int unsigned    BTN_ENTER = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_DEFUSED,
    ST_LOCKED
  } state_e;

  // Synchronisers
  logic [1:0]            btn_meta_q;
  logic [1:0]            btn_sync_q;
  logic [3:0]            digit_meta_q;
  logic [3:0]            digit_sync_q;

  // Debounce and press detection
  logic [1:0][CNT_W-1:0] db_cnt_q;
  logic [1:0][CNT_W-1:0] db_cnt_d;
  logic [1:0]            db_lvl_q;
  logic [1:0]            db_lvl_d;
  logic [1:0]            db_lvl_dly_q;
  logic [1:0]            press_q;
  logic                  arm_press;
  logic                  enter_press;

  // FSM and registered outputs
  state_e                state_q;
  logic [31:0]           entry_q;
  logic [3:0]            digits_q;
  logic [3:0]            attempts_q;
  logic [3:0]            attempts_inc;
  logic                  start_q;
  logic                  defused_q;
  logic                  locked_q;
  logic                  digit_valid;
  logic                  code_match;

  // Two-flop synchronisers on every raw input.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      digit_meta_q <= '0;
      digit_sync_q <= '0;
    end else begin
      btn_meta_q   <= {io.btn_enter, io.btn_arm};
      btn_sync_q   <= btn_meta_q;
      digit_meta_q <= io.digit_in;
      digit_sync_q <= digit_meta_q;
    end
  end

  // Debounce next state: count while synchronised value disagrees with the
  // debounced level, flip the level once the count is complete.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (btn_sync_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) begin
          db_lvl_d[i] = btn_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and registered rising-edge press pulses.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      db_cnt_q     <= '0;
      db_lvl_q     <= '0;
      db_lvl_dly_q <= '0;
      press_q      <= '0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      db_lvl_q     <= db_lvl_d;
      db_lvl_dly_q <= db_lvl_q;
      press_q      <= db_lvl_q & ~db_lvl_dly_q;
    end
  end

  assign arm_press   = press_q[BTN_ARM];
  assign enter_press = press_q[BTN_ENTER];

  // Helper terms for the FSM.
  always_comb begin
    digit_valid  = (digit_sync_q <= 4'd9);
    code_match   = ((entry_q & CODE_MASK) == SECRET_MASKED);
    attempts_inc = attempts_q + 4'd1;
  end

  // Code-entry FSM with registered outputs.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      digits_q   <= '0;
      attempts_q <= '0;
      start_q    <= 1'b0;
      defused_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm_press) begin
            start_q  <= 1'b1;
            entry_q  <= '0;
            digits_q <= '0;
            state_q  <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          // A full entry register moves to CHECK on the edge after the last
          // accept, so the comparison sees the completed code.
          if (digits_q == DIGITS_FULL) begin
            state_q <= ST_CHECK;
          end else if (enter_press && digit_valid) begin
            entry_q  <= {entry_q[27:0], digit_sync_q};
            digits_q <= digits_q + 4'd1;
          end
        end
        ST_CHECK: begin
          if (code_match) begin
            defused_q <= 1'b1;
            state_q   <= ST_DEFUSED;
          end else if (attempts_q != ATTEMPTS_MAX) begin
            attempts_q <= attempts_inc;
            if (attempts_inc == ATTEMPTS_MAX) begin
              locked_q <= 1'b1;
              state_q  <= ST_LOCKED;
            end else begin
              entry_q  <= '0;
              digits_q <= '0;
              state_q  <= ST_ENTRY;
            end
          end else begin
            locked_q <= 1'b1;
            state_q  <= ST_LOCKED;
          end
        end
        ST_DEFUSED: begin
          defused_q <= 1'b1;
        end
        ST_LOCKED: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign io.start_countdown = start_q;
  assign io.defused         = defused_q;
  assign io.locked_out      = locked_q;
  assign io.digits_entered  = digits_q;
  assign io.attempts_used   = attempts_q;

endmodule

// File: tb/tb_bomb_defuse_input.sv
// Directed/randomised bench for bomb_defuse_input with a behavioural model
// of code entry (digit queue, decimal compare, attempt count).
module tb_bomb_defuse_input;

  logic clk = 1'b0;
  logic async_nreset;

  always #5 clk = ~clk;

  bomb_defuse_input_if bus ();

  bomb_defuse_input #(
    .DEBOUNCE_CYCLES (4),
    .CODE_DIGITS     (4),
    .SECRET_CODE     (32'h0000_1234),
    .MAX_ATTEMPTS    (3)
  ) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .io           (bus)
  );

  int total = 0;
  int bad   = 0;

  // Pulse counting for "exactly one start pulse" checks.
  int n_start    = 0;
  int exp_nstart = 0;

  // Behavioural model.
  bit m_active;
  bit m_def;
  bit m_lock;
  int m_att;
  int m_code[$];

  always @(negedge clk) begin
    if (bus.start_countdown === 1'b1) n_start++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input bit exp_start);
    check({tag, ".start"},    32'(bus.start_countdown), 32'(exp_start));
    check({tag, ".defused"},  32'(bus.defused),         32'(m_def));
    check({tag, ".locked"},   32'(bus.locked_out),      32'(m_lock));
    check({tag, ".digits"},   32'(bus.digits_entered),  32'(m_code.size()));
    check({tag, ".attempts"}, 32'(bus.attempts_used),   32'(m_att));
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_def    = 1'b0;
    m_lock   = 1'b0;
    m_att    = 0;
    m_code.delete();
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    async_nreset = 1'b0;
    bus.btn_arm   = 1'b0;
    bus.btn_enter = 1'b0;
    model_reset();
    #1;
    chk_all(tag, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    async_nreset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Short raw pulse (1..3 cycles) that must be rejected by the debouncer.
  task automatic glitch(input string tag, input bit arm);
    int k;
    k = $urandom_range(1, 3);
    @(posedge clk);
    #1;
    if (arm) bus.btn_arm = 1'b1;
    else     bus.btn_enter = 1'b1;
    bus.digit_in = 4'($urandom_range(0, 9));
    repeat (k) @(posedge clk);
    #1;
    bus.btn_arm   = 1'b0;
    bus.btn_enter = 1'b0;
    repeat (14) @(negedge clk);
    chk_all(tag, 1'b0);
    check({tag, ".npulse"}, 32'(n_start), 32'(exp_nstart));
  endtask

  // Clean held press. Raw goes high just after edge t; its effect is
  // visible in the cycle starting at edge t+8.
  task automatic press(input string tag, input bit arm, input logic [3:0] d);
    int hold;
    int val;
    bit exp_start;
    bit complete;
    hold      = $urandom_range(0, 4);
    exp_start = 1'b0;
    complete  = 1'b0;
    @(posedge clk);
    #1;
    bus.digit_in = d;
    if (arm) bus.btn_arm = 1'b1;
    else     bus.btn_enter = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk_all({tag, ".pre"}, 1'b0);
    if (arm) begin
      if (!m_active && !m_def && !m_lock) begin
        exp_start = 1'b1;
        exp_nstart++;
        m_active = 1'b1;
        m_code.delete();
      end
    end else if (m_active && d <= 4'd9) begin
      m_code.push_back(int'(d));
      complete = (m_code.size() == 4);
    end
    @(negedge clk);
    chk_all({tag, ".act"}, exp_start);
    if (complete) begin
      @(negedge clk);
      chk_all({tag, ".chk"}, 1'b0);
      val = 0;
      foreach (m_code[i]) val = val * 10 + m_code[i];
      if (val == 1234) begin
        m_def    = 1'b1;
        m_active = 1'b0;
      end else begin
        m_att++;
        if (m_att == 3) begin
          m_lock   = 1'b1;
          m_active = 1'b0;
        end else begin
          m_code.delete();
        end
      end
      @(negedge clk);
      chk_all({tag, ".res"}, 1'b0);
    end else begin
      @(negedge clk);
      check({tag, ".once"}, 32'(bus.start_countdown), 32'd0);
    end
    repeat (hold + 1) @(posedge clk);
    #1;
    bus.btn_arm   = 1'b0;
    bus.btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    check({tag, ".npulse"}, 32'(n_start), 32'(exp_nstart));
  endtask

  // Four digits, optionally with one invalid digit before position bad_pos.
  task automatic enter_code(input string tag, input int c0, input int c1,
                            input int c2, input int c3, input int bad_pos);
    int c[4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++) begin
      if (i == bad_pos) press({tag, ".inv"}, 1'b0, 4'($urandom_range(10, 15)));
      press($sformatf("%s.d%0d", tag, i), 1'b0, 4'(c[i]));
    end
  endtask

  task automatic wrong_code(input string tag);
    int c[4];
    do begin
      for (int i = 0; i < 4; i++) c[i] = $urandom_range(0, 9);
    end while (c[0] == 1 && c[1] == 2 && c[2] == 3 && c[3] == 4);
    enter_code(tag, c[0], c[1], c[2], c[3], $urandom_range(0, 4));
  endtask

  initial begin
    bus.btn_arm   = 1'b0;
    bus.btn_enter = 1'b0;
    bus.digit_in  = 4'd0;
    async_nreset  = 1'b0;
    model_reset();

    // Reset and glitch rejection in IDLE.
    do_reset("rst0");
    glitch("gl_arm", 1'b1);
    glitch("gl_enter", 1'b0);

    // Enter ignored in IDLE, then arm; second arm ignored in ENTRY.
    press("idle_enter", 1'b0, 4'd7);
    press("arm", 1'b1, 4'd0);
    press("arm_again", 1'b1, 4'd0);
    glitch("gl_entry", 1'b0);

    // Correct code with an invalid digit in the middle.
    press("c1", 1'b0, 4'd1);
    press("inv", 1'b0, 4'hA);
    press("c2", 1'b0, 4'd2);
    press("c3", 1'b0, 4'd3);
    press("c4", 1'b0, 4'd4);
    press("def_arm", 1'b1, 4'd0);
    press("def_enter", 1'b0, 4'd5);

    // Lockout after three wrong codes; a correct code afterwards is ignored.
    do_reset("rst1");
    press("arm1", 1'b1, 4'd0);
    enter_code("w1", 1, 2, 3, 5, -1);
    wrong_code("w2");
    wrong_code("w3");
    enter_code("late", 1, 2, 3, 4, -1);

    // Reset mid-entry loses progress and requires a new arm press.
    do_reset("rst2");
    press("arm2", 1'b1, 4'd0);
    press("m1", 1'b0, 4'd1);
    press("m2", 1'b0, 4'd2);
    do_reset("midrst");
    press("post_enter", 1'b0, 4'd1);
    press("arm3", 1'b1, 4'd0);
    wrong_code("w4");
    enter_code("good", 1, 2, 3, 4, $urandom_range(0, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety timeout so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
